// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data front end for a single-port SRAM with a
// one-cycle registered read.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_if_req/i_if_addr           fetch request (read only)
//   o_if_ack/o_if_rdata          fetch completion pulse and held word
//   i_dm_req/i_dm_we/i_dm_addr   data request, direction, address
//   i_dm_wdata                   data write word
//   o_dm_ack/o_dm_rdata          data completion pulse and held read word
//   o_sram_ce/we/addr/data       SRAM command
//   i_sram_data                  SRAM read word
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise the data port has fixed priority.

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_ack,
  output logic [WORD_WIDTH-1:0] o_if_rdata,
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [ADDR_WIDTH-1:0] i_dm_addr,
  input  logic [WORD_WIDTH-1:0] i_dm_wdata,
  output logic                  o_dm_ack,
  output logic [WORD_WIDTH-1:0] o_dm_rdata,
  output logic                  o_sram_ce,
  output logic                  o_sram_we,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [WORD_WIDTH-1:0] o_sram_data,
  input  logic [WORD_WIDTH-1:0] i_sram_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

  state_t                state;
  logic                  cmd_we;
  logic                  cmd_dm;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [WORD_WIDTH-1:0] cmd_wdata;
  logic                  ce_q;
  logic                  we_q;
  logic                  any_req;
  logic                  grant_dm;

  assign any_req = i_if_req | i_dm_req;

`ifdef MEM_ARB_RR_EN
  // 1 = data port was granted last; reset favours data on first tie
  logic last_dm;

  assign grant_dm = i_dm_req & (~i_if_req | ~last_dm);
`else
  assign grant_dm = i_dm_req;
`endif

  // Reset must kill an in-flight write in the very cycle it is raised,
  // so enables are gated combinationally on top of the registers.
  assign o_sram_ce   = ce_q & ~rst;
  assign o_sram_we   = we_q & ~rst;
  assign o_sram_addr = cmd_addr;
  assign o_sram_data = cmd_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_we     <= 1'b0;
      cmd_dm     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      o_if_ack   <= 1'b0;
      o_dm_ack   <= 1'b0;
      o_if_rdata <= '0;
      o_dm_rdata <= '0;
`ifdef MEM_ARB_RR_EN
      last_dm    <= 1'b0;
`endif
    end else begin
      o_if_ack <= 1'b0;
      o_dm_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            cmd_dm <= grant_dm;
            cmd_we <= grant_dm & i_dm_we;
            we_q   <= grant_dm & i_dm_we;
            ce_q   <= 1'b1;
            state  <= ACCESS;
            if (grant_dm) begin
              cmd_addr  <= i_dm_addr;
              cmd_wdata <= i_dm_wdata;
            end else begin
              cmd_addr  <= i_if_addr;
            end
`ifdef MEM_ARB_RR_EN
            last_dm <= grant_dm;
`endif
          end
        end
        ACCESS: begin
          we_q <= 1'b0;
          if (cmd_we) begin
            ce_q     <= 1'b0;
            o_dm_ack <= 1'b1;
            state    <= RESP;
          end else begin
            // keep ce high so the SRAM drives its output next cycle
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          ce_q  <= 1'b0;
          state <= RESP;
          if (cmd_dm) begin
            o_dm_rdata <= i_sram_data;
            o_dm_ack   <= 1'b1;
          end else begin
            o_if_rdata <= i_sram_data;
            o_if_ack   <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed bench with a
// transaction-level reference model and a behavioural SRAM.

module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int WW = 16;

  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [15:0] wdata;
  } op_t;

  logic          clk;
  logic          rst;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_ack;
  logic [WW-1:0] o_if_rdata;
  logic          i_dm_req;
  logic          i_dm_we;
  logic [AW-1:0] i_dm_addr;
  logic [WW-1:0] i_dm_wdata;
  logic          o_dm_ack;
  logic [WW-1:0] o_dm_rdata;
  logic          o_sram_ce;
  logic          o_sram_we;
  logic [AW-1:0] o_sram_addr;
  logic [WW-1:0] o_sram_data;
  logic [WW-1:0] i_sram_data;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_ack    (o_if_ack),
    .o_if_rdata  (o_if_rdata),
    .i_dm_req    (i_dm_req),
    .i_dm_we     (i_dm_we),
    .i_dm_addr   (i_dm_addr),
    .i_dm_wdata  (i_dm_wdata),
    .o_dm_ack    (o_dm_ack),
    .o_dm_rdata  (o_dm_rdata),
    .o_sram_ce   (o_sram_ce),
    .o_sram_we   (o_sram_we),
    .o_sram_addr (o_sram_addr),
    .o_sram_data (o_sram_data),
    .i_sram_data (i_sram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference contents, owned by the bench
  logic [WW-1:0] ref_mem [0:4095];

  // behavioural SRAM: registered read, output driven only while reading
  logic [WW-1:0] sram_mem [0:4095];
  logic [WW-1:0] sram_q;
  logic          init_go;

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < 4096; i++) sram_mem[i] <= ref_mem[i];
    end else begin
      if (o_sram_ce && o_sram_we) sram_mem[o_sram_addr] <= o_sram_data;
      if (o_sram_ce && !o_sram_we) sram_q <= sram_mem[o_sram_addr];
    end
  end

  assign i_sram_data = (o_sram_ce && !o_sram_we) ? sram_q : 16'hDEAD;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // requesters
  op_t         dm_q[$];
  logic [11:0] if_q[$];
  op_t         dm_cur;
  logic [11:0] if_cur;
  bit          dm_pend;
  bit          if_pend;
  bit          rand_mode;

  // reference model: current transaction and held results
  int          m_gnt;
  int          m_ack;
  bit          m_dm;
  bit          m_we;
  bit          m_last_dm;
  bit          pick_dm;
  logic [11:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rd;
  logic [15:0] m_if_rd;
  logic [15:0] m_dm_rd;

  // observations for directed checks
  int ce_cnt;
  int if_ack_cnt;
  int last_dm_ack;
  int last_if_ack;
  int last_dm_gnt;
  bit ack_seq[$];
  int dm_ack_hist[$];

  function automatic logic [11:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 12'h000;
      1: return 12'hFFF;
      default: return 12'(32'h100 + $urandom_range(0, 15));
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.we    = 1'($urandom_range(0, 1));
    o.addr  = rand_addr();
    o.wdata = 16'($urandom);
    return o;
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
    if (cyc == m_ack) begin
      if (m_dm && m_we) ref_mem[m_addr] = m_wdata;
      else if (m_dm)    m_dm_rd = m_rd;
      else              m_if_rd = m_rd;
    end
    chk("if_ack", o_if_ack, (cyc == m_ack && !m_dm));
    chk("dm_ack", o_dm_ack, (cyc == m_ack && m_dm));
    chk("one_ack", o_if_ack & o_dm_ack, 0);
    chk("sram_ce", o_sram_ce, (cyc > m_gnt && cyc < m_ack));
    chk("sram_we", o_sram_we, (m_we && cyc == m_gnt + 1));
    if (cyc > m_gnt && cyc < m_ack)
      chk("sram_addr", o_sram_addr, m_addr);
    if (m_we && cyc == m_gnt + 1)
      chk("sram_data", o_sram_data, m_wdata);
    chk("if_rdata", o_if_rdata, m_if_rd);
    chk("dm_rdata", o_dm_rdata, m_dm_rd);

    ce_cnt += int'(o_sram_ce);
    if (o_if_ack) begin
      if_ack_cnt++;
      last_if_ack = cyc;
      ack_seq.push_back(1'b0);
      if_pend = 1'b0;
    end
    if (o_dm_ack) begin
      last_dm_ack = cyc;
      dm_ack_hist.push_back(cyc);
      ack_seq.push_back(1'b1);
      dm_pend = 1'b0;
    end

    if (rand_mode) begin
      if (!dm_pend && dm_q.size() == 0 && $urandom_range(0, 2) == 0)
        dm_q.push_back(rand_op());
      if (!if_pend && if_q.size() == 0 && $urandom_range(0, 2) == 0)
        if_q.push_back(rand_addr());
    end
    if (!dm_pend && dm_q.size() > 0) begin
      dm_cur  = dm_q.pop_front();
      dm_pend = 1'b1;
    end
    if (!if_pend && if_q.size() > 0) begin
      if_cur  = if_q.pop_front();
      if_pend = 1'b1;
    end
    i_dm_req   = dm_pend;
    i_dm_we    = dm_cur.we;
    i_dm_addr  = dm_cur.addr;
    i_dm_wdata = dm_cur.wdata;
    i_if_req   = if_pend;
    i_if_addr  = if_cur;

    // a new transaction may start only once the previous ack is over
    if (cyc > m_ack && (if_pend || dm_pend)) begin
`ifdef MEM_ARB_RR_EN
      pick_dm = dm_pend && (!if_pend || !m_last_dm);
`else
      pick_dm = dm_pend;
`endif
      m_last_dm = pick_dm;
      m_dm      = pick_dm;
      m_gnt     = cyc;
      if (pick_dm) begin
        m_we        = dm_cur.we;
        m_addr      = dm_cur.addr;
        m_wdata     = dm_cur.wdata;
        last_dm_gnt = cyc;
      end else begin
        m_we   = 1'b0;
        m_addr = if_cur;
      end
      m_rd  = ref_mem[m_addr];
      m_ack = cyc + (m_we ? 2 : 3);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while ((dm_pend || if_pend || dm_q.size() > 0 || if_q.size() > 0 ||
            cyc <= m_ack) && k < 300) begin
      step();
      k++;
    end
    chk("drain_timeout", (k >= 300), 0);
  endtask

  task automatic dm_op(input bit we, input logic [11:0] a,
                       input logic [15:0] d);
    op_t o;
    o.we    = we;
    o.addr  = a;
    o.wdata = d;
    dm_q.push_back(o);
  endtask

  initial begin
    int k;
    rst        = 1'b1;
    init_go    = 1'b1;
    rand_mode  = 1'b0;
    dm_pend    = 1'b0;
    if_pend    = 1'b0;
    dm_cur     = '{1'b0, 12'h0, 16'h0};
    if_cur     = 12'h0;
    i_if_req   = 1'b0;
    i_if_addr  = '0;
    i_dm_req   = 1'b0;
    i_dm_we    = 1'b0;
    i_dm_addr  = '0;
    i_dm_wdata = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 16'($urandom);
    ref_mem[12'hFFF] = 16'h1234;
    ref_mem[12'h000] = 16'hA5A5;
    ref_mem[12'h020] = 16'h0F0F;
    m_gnt = -100; m_ack = 0; m_dm = 0; m_we = 0; m_last_dm = 0;
    m_addr = 0; m_wdata = 0; m_rd = 0; m_if_rd = 0; m_dm_rd = 0;
    ce_cnt = 0; if_ack_cnt = 0;
    last_dm_ack = 0; last_if_ack = 0; last_dm_gnt = 0;

    repeat (3) @(posedge clk);
    #1 init_go = 1'b0;
    @(negedge clk);
    chk("rst_ce", o_sram_ce, 0);
    chk("rst_we", o_sram_we, 0);
    chk("rst_addr", o_sram_addr, 0);
    chk("rst_data", o_sram_data, 0);
    chk("rst_if_ack", o_if_ack, 0);
    chk("rst_dm_ack", o_dm_ack, 0);
    chk("rst_if_rdata", o_if_rdata, 0);
    chk("rst_dm_rdata", o_dm_rdata, 0);
    rst = 1'b0;

    // write then read back
    ce_cnt = 0; if_ack_cnt = 0;
    dm_op(1'b1, 12'h012, 16'hBEEF);
    wait_done();
    chk("wr_ce_cycles", ce_cnt, 1);
    chk("wr_latency", last_dm_ack - last_dm_gnt, 2);
    chk("wr_no_if_ack", if_ack_cnt, 0);
    ce_cnt = 0;
    dm_op(1'b0, 12'h012, 16'h0000);
    wait_done();
    chk("rd_ce_cycles", ce_cnt, 2);
    chk("rd_latency", last_dm_ack - last_dm_gnt, 3);
    chk("rd_data", o_dm_rdata, 16'hBEEF);

    // fetch at both address extremes
    if_q.push_back(12'hFFF);
    wait_done();
    chk("if_fff", o_if_rdata, 16'h1234);
    if_q.push_back(12'h000);
    wait_done();
    chk("if_000", o_if_rdata, 16'hA5A5);
    chk("dm_kept", o_dm_rdata, 16'hBEEF);

    // simultaneous requests
    ack_seq.delete();
    dm_op(1'b0, 12'h010, 16'h0000);
    if_q.push_back(12'h010);
`ifdef MEM_ARB_RR_EN
    dm_op(1'b0, 12'h011, 16'h0000);
    if_q.push_back(12'h011);
    wait_done();
    chk("rr_count", ack_seq.size(), 4);
    if (ack_seq.size() == 4) begin
      chk("rr_0", ack_seq[0], 1);
      chk("rr_1", ack_seq[1], 0);
      chk("rr_2", ack_seq[2], 1);
      chk("rr_3", ack_seq[3], 0);
    end
`else
    wait_done();
    chk("arb_count", ack_seq.size(), 2);
    if (ack_seq.size() == 2) chk("arb_first_dm", ack_seq[0], 1);
    chk("arb_gap", last_if_ack - last_dm_ack, 4);
`endif

    // reset during the ACCESS cycle of a write
    dm_op(1'b1, 12'h020, 16'h5555);
    k = 0;
    do begin
      step();
      k++;
    end while (m_gnt != cyc && k < 20);
    chk("abort_grant_timeout", (k >= 20), 0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    dm_pend  = 1'b0;
    i_dm_req = 1'b0;
    @(negedge clk);
    cyc++;
    chk("abort_ce", o_sram_ce, 0);
    chk("abort_we", o_sram_we, 0);
    chk("abort_ack", o_dm_ack | o_if_ack, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_gnt = -100; m_ack = cyc; m_we = 0;
    m_if_rd = 0; m_dm_rd = 0; m_last_dm = 0;
    repeat (3) step();
    dm_op(1'b0, 12'h020, 16'h0000);
    wait_done();
    chk("abort_old", o_dm_rdata, 16'h0F0F);
    chk("abort_latency", last_dm_ack - last_dm_gnt, 3);

    // back-to-back writes
    dm_ack_hist.delete();
    dm_op(1'b1, 12'h030, 16'h1111);
    dm_op(1'b1, 12'h031, 16'h2222);
    wait_done();
    chk("b2b_count", dm_ack_hist.size(), 2);
    if (dm_ack_hist.size() == 2)
      chk("b2b_gap", dm_ack_hist[1] - dm_ack_hist[0], 3);

    // random traffic
    rand_mode = 1'b1;
    repeat (800) step();
    rand_mode = 1'b0;
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
